// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared types, sizes and helpers for the mvm host controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

    localparam int MVM_K  = 4;
    localparam int MVM_B  = 8;
    localparam int NWORDS = MVM_K * MVM_K + MVM_K;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int IDX_W  = $clog2(MVM_K + 1);

    typedef logic signed [MVM_B-1:0]   mvm_word_t;
    typedef logic signed [2*MVM_B-1:0] mvm_result_t;

    typedef enum logic [3:0] {
        FILL     = 4'd0,
        LOAD_M   = 4'd1,
        STREAM_M = 4'd2,
        GAP1     = 4'd3,
        LOAD_V   = 4'd4,
        STREAM_V = 4'd5,
        GAP2     = 4'd6,
        START    = 4'd7,
        WAIT     = 4'd8,
        COLLECT  = 4'd9,
        DRAIN    = 4'd10
    } mvm_state_t;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_host_buf.sv
`default_nettype none
// ============================================================================
// Module      : mvm_host_buf
// Description : Single-write, single-read register array with async read.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_host_buf #(
    parameter int DEPTH = 20,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mvm_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mvm_host_ctrl
// Description : Buffers one matrix/vector job, replays it gap-free to the mvm
//               core, collects the K results and streams them out.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_host_ctrl
    import mvm_pkg::*;
#(
    parameter int K = MVM_K,
    parameter int B = MVM_B
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*B-1:0] out_data,
    output logic           busy,
    output logic           mvm_loadMatrix,
    output logic           mvm_loadVector,
    output logic           mvm_start,
    output logic [B-1:0]   mvm_data_in,
    input  logic           mvm_done,
    input  logic [2*B-1:0] mvm_data_out
);

    localparam int JOB_WORDS = K * K + K;
    localparam int JCNT_W    = cnt_width(JOB_WORDS);
    localparam int RIDX_W    = cnt_width(K);
    localparam int JAW       = $clog2(JOB_WORDS);
    localparam int RAW       = (K > 1) ? $clog2(K) : 1;

    localparam logic [JCNT_W-1:0] JOB_LAST  = JCNT_W'(JOB_WORDS - 1);
    localparam logic [JCNT_W-1:0] JOB_END   = JCNT_W'(JOB_WORDS);
    localparam logic [JCNT_W-1:0] MAT_END   = JCNT_W'(K * K);
    localparam logic [JCNT_W-1:0] JCNT_ONE  = JCNT_W'(1);
    localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(K - 1);
    localparam logic [RIDX_W-1:0] RIDX_ONE  = RIDX_W'(1);

    mvm_state_t          r_state, w_state_nxt;
    logic [JCNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [RIDX_W-1:0]   r_idx, w_idx_nxt;
    logic [B-1:0]        r_data_in, w_data_nxt;
    logic                r_armed, w_armed_nxt;
    logic                w_job_we, w_res_we;
    logic [B-1:0]        w_job_rdata;
    logic [2*B-1:0]      w_res_rdata;

    // One counter both fills the job buffer and walks it during replay.
    mvm_host_buf #(
        .DEPTH (JOB_WORDS),
        .WIDTH (B)
    ) u_job_buf (
        .clk     (clk),
        .i_we    (w_job_we),
        .i_waddr (r_cnt[JAW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_cnt[JAW-1:0]),
        .o_rdata (w_job_rdata)
    );

    mvm_host_buf #(
        .DEPTH (K),
        .WIDTH (2 * B)
    ) u_res_buf (
        .clk     (clk),
        .i_we    (w_res_we),
        .i_waddr (r_idx[RAW-1:0]),
        .i_wdata (mvm_data_out),
        .i_raddr (r_idx[RAW-1:0]),
        .o_rdata (w_res_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FILL;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data_in <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_data_in <= w_data_nxt;
            r_armed   <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_data_nxt     = r_data_in;
        w_armed_nxt    = r_armed;
        w_job_we       = 1'b0;
        w_res_we       = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        mvm_loadMatrix = 1'b0;
        mvm_loadVector = 1'b0;
        mvm_start      = 1'b0;

        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_job_we = 1'b1;
                    if (r_cnt == JOB_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = LOAD_M;
                    end else begin
                        w_cnt_nxt = r_cnt + JCNT_ONE;
                    end
                end
            end
            // The data register is loaded one cycle ahead so each word is
            // on mvm_data_in exactly in the cycle after the previous one.
            LOAD_M: begin
                mvm_loadMatrix = 1'b1;
                w_data_nxt     = w_job_rdata;
                w_cnt_nxt      = r_cnt + JCNT_ONE;
                w_state_nxt    = STREAM_M;
            end
            STREAM_M: begin
                if (r_cnt == MAT_END) begin
                    w_state_nxt = GAP1;
                end else begin
                    w_data_nxt = w_job_rdata;
                    w_cnt_nxt  = r_cnt + JCNT_ONE;
                end
            end
            GAP1: begin
                w_state_nxt = LOAD_V;
            end
            LOAD_V: begin
                mvm_loadVector = 1'b1;
                w_data_nxt     = w_job_rdata;
                w_cnt_nxt      = r_cnt + JCNT_ONE;
                w_state_nxt    = STREAM_V;
            end
            STREAM_V: begin
                if (r_cnt == JOB_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = GAP2;
                end else begin
                    w_data_nxt = w_job_rdata;
                    w_cnt_nxt  = r_cnt + JCNT_ONE;
                end
            end
            GAP2: begin
                w_state_nxt = START;
            end
            START: begin
                mvm_start   = 1'b1;
                w_armed_nxt = 1'b0;
                w_state_nxt = WAIT;
            end
            // A done left high by the previous job only counts once it has
            // been observed low.
            WAIT: begin
                if (!mvm_done) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                w_res_we = 1'b1;
                if (r_idx == RIDX_LAST) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_idx_nxt = r_idx + RIDX_ONE;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_idx == RIDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = FILL;
                    end else begin
                        w_idx_nxt = r_idx + RIDX_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    assign out_data    = out_valid ? w_res_rdata : '0;
    assign busy        = (r_state != FILL) || (r_cnt != '0);
    assign mvm_data_in = r_data_in;

endmodule
`default_nettype wire

// File: tb/tb_mvm_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvm_host_ctrl
// Description : Directed + random jobs against a behavioural mvm core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_host_ctrl;
    import mvm_pkg::*;

    localparam int K        = MVM_K;
    localparam int B        = MVM_B;
    localparam int NW       = K * K + K;
    localparam int DONE_LAT = 7;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [B-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*B-1:0] out_data;
    logic           busy;
    logic           mvm_loadMatrix;
    logic           mvm_loadVector;
    logic           mvm_start;
    logic [B-1:0]   mvm_data_in;
    logic           mvm_done;
    logic [2*B-1:0] mvm_data_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    bit mon_kill = 1'b0;

    logic [B-1:0]   cur_A [K*K];
    logic [B-1:0]   cur_x [K];
    logic [2*B-1:0] exp_q [$];

    logic [B-1:0]   core_A [K*K];
    logic [B-1:0]   core_x [K];
    int             core_lm, core_lv, core_st;

    mvm_host_ctrl #(.K(K), .B(B)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .mvm_loadMatrix (mvm_loadMatrix),
        .mvm_loadVector (mvm_loadVector),
        .mvm_start      (mvm_start),
        .mvm_data_in    (mvm_data_in),
        .mvm_done       (mvm_done),
        .mvm_data_out   (mvm_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // y = A*x on the signed words, truncated to the result width.
    function automatic logic [2*B-1:0] ref_y(input int i);
        int acc = 0;
        for (int j = 0; j < K; j++)
            acc += int'(mvm_word_t'(cur_A[i*K+j])) * int'(mvm_word_t'(cur_x[j]));
        return acc[2*B-1:0];
    endfunction

    function automatic logic [2*B-1:0] core_y(input int i);
        int acc = 0;
        for (int j = 0; j < K; j++)
            acc += int'(mvm_word_t'(core_A[i*K+j])) * int'(mvm_word_t'(core_x[j]));
        return acc[2*B-1:0];
    endfunction

    // Core model: captures words by cycle offset from the load pulses; done
    // stays high after a job and drops two cycles after the next start.
    always @(posedge clk) begin
        if (reset) begin
            core_lm      <= -1000;
            core_lv      <= -1000;
            core_st      <= -1000;
            mvm_done     <= 1'b0;
            mvm_data_out <= '0;
        end else begin
            if (mvm_loadMatrix) core_lm <= cyc;
            if (mvm_loadVector) core_lv <= cyc;
            if (mvm_start)      core_st <= cyc;
            if (cyc > core_lm && cyc <= core_lm + K*K) core_A[cyc-core_lm-1] <= mvm_data_in;
            if (cyc > core_lv && cyc <= core_lv + K)   core_x[cyc-core_lv-1] <= mvm_data_in;
            if (cyc == core_st + 1)                    mvm_done <= 1'b0;
            else if (cyc == core_st + DONE_LAT - 1)    mvm_done <= 1'b1;
            if (cyc >= core_st + DONE_LAT && cyc < core_st + DONE_LAT + K)
                mvm_data_out <= core_y(cyc - core_st - DONE_LAT);
            else
                mvm_data_out <= (2*B)'($urandom);
        end
    end

    task automatic monitor();
        int lm = -1000;
        bit p_lm = 1'b0, p_lv = 1'b0, p_st = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || mon_kill) begin
                lm = -1000;
            end else begin
                if (mvm_loadMatrix) lm = cyc;
                if (mvm_loadMatrix || mvm_loadVector || mvm_start) begin
                    check("pulse_onehot", int'(mvm_loadMatrix) + int'(mvm_loadVector) + int'(mvm_start), 1);
                    check("pulse_in_drain", out_valid, 0);
                end
                if (mvm_loadMatrix) check("lm_width", p_lm, 0);
                if (mvm_loadVector) begin
                    check("lv_width", p_lv, 0);
                    check("lv_time", cyc - lm, K*K + 2);
                end
                if (mvm_start) begin
                    check("st_width", p_st, 0);
                    check("st_time", cyc - lm, K*K + K + 4);
                end
                if (lm >= 0 && cyc > lm && cyc <= lm + K*K)
                    check("stream_m", mvm_data_in, cur_A[cyc-lm-1]);
                if (lm >= 0 && cyc == lm + K*K + 1)
                    check("gap1_hold", mvm_data_in, cur_A[K*K-1]);
                if (lm >= 0 && cyc > lm + K*K + 2 && cyc <= lm + K*K + 2 + K)
                    check("stream_v", mvm_data_in, cur_x[cyc-lm-K*K-3]);
            end
            p_lm = mvm_loadMatrix;
            p_lv = mvm_loadVector;
            p_st = mvm_start;
        end
    endtask

    task automatic send_job(input bit gaps, input bit b2b);
        for (int w = 0; w < NW; w++) begin
            int t = 0;
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (w < K*K) ? cur_A[w] : cur_x[w-K*K];
            if (w == 0 && b2b) check("b2b_accept", in_ready, 1);
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("in_ready_wait", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_job(input int stall_idx);
        int hs_prev = 0;
        out_ready = 1'b1;
        for (int i = 0; i < K; i++) begin
            int t = 0;
            @(negedge clk);
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("out_valid_wait", out_valid, 1);
            check("busy_drain", busy, 1);
            if (i == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, exp_q[i]);
                    check("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            check("result", out_data, exp_q[i]);
            if (i > 0 && stall_idx < 0) check("no_bubble", cyc - hs_prev, 1);
            hs_prev = cyc;
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    task automatic job_identity();
        for (int i = 0; i < K*K; i++) cur_A[i] = (i / K == i % K) ? B'(1) : B'(0);
        for (int j = 0; j < K; j++) cur_x[j] = B'(j + 1);
        exp_q.delete();
        for (int i = 0; i < K; i++) exp_q.push_back((2*B)'(i + 1));
    endtask

    task automatic job_random();
        for (int i = 0; i < K*K; i++) cur_A[i] = B'($urandom);
        for (int j = 0; j < K; j++) cur_x[j] = B'($urandom);
        exp_q.delete();
        for (int i = 0; i < K; i++) exp_q.push_back(ref_y(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_pulses"}, {mvm_loadMatrix, mvm_loadVector, mvm_start}, 0);
        check({tag, "_data_in"}, mvm_data_in, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        job_identity();
        send_job(1'b0, 1'b0);
        recv_job(-1);
        check_idle();

        for (int i = 0; i < K*K; i++) cur_A[i] = 8'hFD;
        for (int j = 0; j < K; j++) cur_x[j] = 8'd5;
        exp_q.delete();
        for (int i = 0; i < K; i++) exp_q.push_back(16'hFFC4);
        send_job(1'b0, 1'b0);
        recv_job(-1);
        check_idle();

        // Same random job: steady input with output stall, then gapped input.
        job_random();
        send_job(1'b0, 1'b0);
        recv_job(1);
        check_idle();
        send_job(1'b1, 1'b0);
        recv_job(-1);
        check_idle();

        // Abort in the middle of the matrix stream.
        job_identity();
        send_job(1'b0, 1'b0);
        begin
            int t = 0;
            while (!mvm_loadMatrix && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("lm_seen", mvm_loadMatrix, 1);
        end
        repeat (6) @(negedge clk);
        mon_kill = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("abort");
        @(negedge clk);
        mon_kill = 1'b0;
        send_job(1'b0, 1'b0);
        recv_job(-1);
        check_idle();

        // Back-to-back: second job starts the cycle after the last handshake.
        job_random();
        send_job(1'b0, 1'b0);
        recv_job(-1);
        job_random();
        send_job(1'b0, 1'b1);
        recv_job(-1);
        check_idle();

        for (int n = 0; n < 3; n++) begin
            job_random();
            send_job(1'($urandom_range(0, 1)), 1'b0);
            recv_job(int'($urandom_range(0, K)) - 1);
            check_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
